// File: rtl/gate_controller.sv
`default_nettype none
// ============================================================================
//  Module   : gate_controller
//  Purpose  : Barrier-gate actuator stage behind the parking occupancy FSM.
//             Sequences the barrier motor through open / hold / close using
//             the limit switches and the vehicle loop sensor, supervises motor
//             travel time, and drives the FULL indicator lamp.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   clock
//    reset       in   synchronous, active-low reset
//    open_req    in   one-cycle open pulse from the occupancy FSM
//    full_req    in   one-cycle full pulse from the occupancy FSM
//    limit_up    in   barrier fully raised
//    limit_down  in   barrier fully lowered
//    car_present in   loop sensor, vehicle under barrier
//    motor_up    out  drive barrier upward
//    motor_down  out  drive barrier downward
//    gate_open   out  barrier held open
//    full_lamp   out  FULL indicator
//    fault       out  motor timeout or limit-switch conflict
//    busy        out  gate is not idle-closed
//  Build option
//    GATE_AUTO_RETRY_EN : when defined, the first motor-timeout fault attempts
//                         one automatic close after HOLD_CYC cycles.
// ============================================================================
module gate_controller #(
    parameter int MOVE_TIMEOUT = 20,
    parameter int HOLD_CYC     = 16,
    parameter int LAMP_CYC     = 12,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic open_req,
    input  logic full_req,
    input  logic limit_up,
    input  logic limit_down,
    input  logic car_present,
    output logic motor_up,
    output logic motor_down,
    output logic gate_open,
    output logic full_lamp,
    output logic fault,
    output logic busy
);

    typedef enum logic [2:0] {
        ST_CLOSED    = 3'd0,
        ST_OPENING   = 3'd1,
        ST_OPEN_HOLD = 3'd2,
        ST_CLOSING   = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // The move timer holds (cycles already spent in the state - 1) at each
    // edge, so comparing against MOVE_TIMEOUT-1 faults on the edge that ends
    // the MOVE_TIMEOUT-th cycle of travel.
    localparam logic [CNT_W-1:0] c_MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_HOLD      = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] c_LAMP      = CNT_W'(LAMP_CYC);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
`ifdef GATE_AUTO_RETRY_EN
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] lamp_q,  lamp_d;
    logic             motor_up_q, motor_down_q, gate_open_q;
    logic             full_lamp_q, fault_q, busy_q;
    logic             fault_d;
    logic             w_conflict;
`ifdef GATE_AUTO_RETRY_EN
    // retry_q: the single automatic close has been used and is in progress.
    // conflict_q: current fault came from a limit conflict, never retried.
    logic             retry_q, retry_d;
    logic             conflict_q, conflict_d;
`endif

    assign w_conflict = limit_up & limit_down;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
`ifdef GATE_AUTO_RETRY_EN
        retry_d    = retry_q;
        conflict_d = conflict_q;
`endif
        if (w_conflict) begin
            state_d = ST_FAULT;
            timer_d = '0;
`ifdef GATE_AUTO_RETRY_EN
            conflict_d = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    timer_d = '0;
                    if (open_req) begin
                        state_d = ST_OPENING;
                    end
                end
                ST_OPENING: begin
                    if (limit_up) begin
                        state_d = ST_OPEN_HOLD;
                        timer_d = c_HOLD;
                    end else if (timer_q == c_MOVE_LAST) begin
                        state_d = ST_FAULT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + c_ONE;
                    end
                end
                ST_OPEN_HOLD: begin
                    if (car_present || open_req) begin
                        timer_d = c_HOLD;
                    end else if (timer_q == '0) begin
                        state_d = ST_CLOSING;
                    end else begin
                        timer_d = timer_q - c_ONE;
                    end
                end
                ST_CLOSING: begin
                    // Safety reverse outranks arrival at the down limit.
                    if (car_present || open_req) begin
                        state_d = ST_OPENING;
                        timer_d = '0;
                    end else if (limit_down) begin
                        state_d = ST_CLOSED;
                        timer_d = '0;
`ifdef GATE_AUTO_RETRY_EN
                        retry_d = 1'b0;
`endif
                    end else if (timer_q == c_MOVE_LAST) begin
                        state_d = ST_FAULT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + c_ONE;
                    end
                end
                ST_FAULT: begin
`ifdef GATE_AUTO_RETRY_EN
                    if (!retry_q && !conflict_q) begin
                        if (timer_q == c_HOLD_LAST) begin
                            state_d = ST_CLOSING;
                            timer_d = '0;
                            retry_d = 1'b1;
                        end else begin
                            timer_d = timer_q + c_ONE;
                        end
                    end
`endif
                end
                default: begin
                    state_d = ST_CLOSED;
                    timer_d = '0;
                end
            endcase
        end
    end

    // FULL lamp timer runs independently of the gate state; a retrigger
    // reloads rather than accumulates.
    always_comb begin
        lamp_d = lamp_q;
        if (full_req) begin
            lamp_d = c_LAMP;
        end else if (lamp_q != '0) begin
            lamp_d = lamp_q - c_ONE;
        end
    end

    // During the retry close the fault indication stays up until the gate
    // actually reaches the down limit.
`ifdef GATE_AUTO_RETRY_EN
    assign fault_d = (state_d == ST_FAULT) || retry_d;
`else
    assign fault_d = (state_d == ST_FAULT);
`endif

    // Outputs are registered from the next state so they line up with the
    // state register and carry no combinational path from inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_CLOSED;
            timer_q      <= '0;
            lamp_q       <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            gate_open_q  <= 1'b0;
            full_lamp_q  <= 1'b0;
            fault_q      <= 1'b0;
            busy_q       <= 1'b0;
`ifdef GATE_AUTO_RETRY_EN
            retry_q      <= 1'b0;
            conflict_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lamp_q       <= lamp_d;
            motor_up_q   <= (state_d == ST_OPENING);
            motor_down_q <= (state_d == ST_CLOSING);
            gate_open_q  <= (state_d == ST_OPEN_HOLD);
            full_lamp_q  <= (lamp_d != '0);
            fault_q      <= fault_d;
            busy_q       <= (state_d != ST_CLOSED);
`ifdef GATE_AUTO_RETRY_EN
            retry_q      <= retry_d;
            conflict_q   <= conflict_d;
`endif
        end
    end

    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign gate_open  = gate_open_q;
    assign full_lamp  = full_lamp_q;
    assign fault      = fault_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_controller
//  Purpose  : Self-checking bench for gate_controller. Directed scenarios
//             followed by randomized traffic against a simple barrier plant,
//             all outputs compared every cycle with a timestamp-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_controller;

    localparam int MOVE_TIMEOUT = 20;
    localparam int HOLD_CYC     = 16;
    localparam int LAMP_CYC     = 12;
    localparam int CNT_W        = 8;

    logic clk;
    logic reset;
    logic open_req, full_req, limit_up, limit_down, car_present;
    logic motor_up, motor_down, gate_open, full_lamp, fault, busy;

    int n_checks = 0;
    int n_errors = 0;

    gate_controller #(
        .MOVE_TIMEOUT (MOVE_TIMEOUT),
        .HOLD_CYC     (HOLD_CYC),
        .LAMP_CYC     (LAMP_CYC),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .open_req    (open_req),
        .full_req    (full_req),
        .limit_up    (limit_up),
        .limit_down  (limit_down),
        .car_present (car_present),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .gate_open   (gate_open),
        .full_lamp   (full_lamp),
        .fault       (fault),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase plus edge timestamps. Durations are derived
    // from "how many edges since X", not from a down/up counter.
    // phase: 0 idle-closed, 1 raising, 2 held open, 3 lowering, 4 faulted
    // ------------------------------------------------------------------
    int m_t        = 0;
    int m_phase    = 0;
    int m_enter    = 0;     // edge at which current phase began
    int m_last     = 0;     // last edge that (re)started the open hold
    int m_lamp_t   = -1000; // edge of the most recent full_req
    bit m_retried  = 0;
    bit m_conflict = 0;

    task automatic model_edge(input bit rst_n, input bit op, input bit fr,
                              input bit lu, input bit ld, input bit car);
        m_t++;
        if (!rst_n) begin
            m_phase = 0; m_lamp_t = -1000; m_retried = 0; m_conflict = 0;
            return;
        end
        if (fr) m_lamp_t = m_t;
        if (lu && ld) begin
            m_phase = 4; m_enter = m_t; m_conflict = 1;
            return;
        end
        case (m_phase)
            0: if (op) begin m_phase = 1; m_enter = m_t; end
            1: begin
                if (lu) begin m_phase = 2; m_last = m_t; end
                else if (m_t - m_enter == MOVE_TIMEOUT) begin m_phase = 4; m_enter = m_t; end
            end
            2: begin
                // Closes once HOLD_CYC quiet cycles have followed the hold start.
                if (car || op) m_last = m_t;
                else if (m_t - m_last == HOLD_CYC + 1) begin m_phase = 3; m_enter = m_t; end
            end
            3: begin
                if (car || op) begin m_phase = 1; m_enter = m_t; end
                else if (ld) begin m_phase = 0; m_retried = 0; end
                else if (m_t - m_enter == MOVE_TIMEOUT) begin m_phase = 4; m_enter = m_t; end
            end
            default: begin
`ifdef GATE_AUTO_RETRY_EN
                if (!m_retried && !m_conflict && (m_t - m_enter == HOLD_CYC)) begin
                    m_phase = 3; m_enter = m_t; m_retried = 1;
                end
`endif
            end
        endcase
    endtask

    task automatic compare_all();
        check("motor_up",   32'(motor_up),   32'(m_phase == 1));
        check("motor_down", 32'(motor_down), 32'(m_phase == 3));
        check("gate_open",  32'(gate_open),  32'(m_phase == 2));
        check("full_lamp",  32'(full_lamp),  32'((m_t - m_lamp_t) < LAMP_CYC));
        check("fault",      32'(fault),      32'((m_phase == 4) || m_retried));
        check("busy",       32'(busy),       32'(m_phase != 0));
    endtask

    // One clock: drive inputs, advance DUT and model, sample 1 ns later.
    task automatic step(input bit rst_n, input bit op, input bit fr,
                        input bit lu, input bit ld, input bit car);
        reset = rst_n; open_req = op; full_req = fr;
        limit_up = lu; limit_down = ld; car_present = car;
        @(posedge clk);
        model_edge(rst_n, op, fr, lu, ld, car);
        #1;
        compare_all();
    endtask

    // Random-phase plant state
    int  pos, travel, car_left, fault_age;
    bit  r_rst, r_op, r_fr, r_lu, r_ld, r_car;

    initial begin
        reset = 1'b0; open_req = 1'b0; full_req = 1'b0;
        limit_up = 1'b0; limit_down = 1'b0; car_present = 1'b0;
        #2;

        // Normal cycle with FULL lamp retriggered at edges 3 and 8.
        step(0, 0, 0, 0, 1, 0);                       // edge 0: reset
        for (int e = 1; e <= 30; e++) begin
            step(1, e == 1, (e == 3) || (e == 8),
                 (e >= 5) && (e <= 22), e >= 26, 0);
            if (e == 27) check("tp_closed_idle", 32'(busy), 32'd0);
            if (e == 2)  check("tp_motor_up_c3", 32'(motor_up), 32'd1);
        end

        // Hold extension, then safety reverse while closing.
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        for (int e = 0; e < 4; e++)  step(1, 0, 0, 0, 0, 0);
        for (int e = 0; e < 30; e++) step(1, 0, 0, 1, 0, 1);
        for (int e = 0; e < 19; e++) step(1, 0, 0, 1, 0, 0);
        check("tp_closing", 32'(motor_down), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);                       // car while closing
        check("tp_reverse", 32'(motor_up), 32'd1);
        step(1, 0, 0, 1, 0, 0);
        check("tp_rehold", 32'(gate_open), 32'd1);

        // Open timeout, later open_req ignored.
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int e = 0; e < 24; e++) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int e = 0; e < 3; e++)  step(1, 0, 0, 0, 0, 0);
`ifndef GATE_AUTO_RETRY_EN
        check("tp_fault_sticky", 32'(fault), 32'd1);
`endif
        for (int e = 0; e < 30; e++) step(1, 0, 0, 0, e >= 20, 0);

        // Sensor conflict from closed, then one reset edge clears it.
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        check("tp_conflict", 32'(fault), 32'd1);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("tp_reset_fault", 32'(fault), 32'd0);

        // Randomized traffic against a barrier plant of random travel length.
        pos = 0; travel = 5; car_left = 0; fault_age = 0;
        for (int i = 0; i < 8000; i++) begin
            r_rst = 1;
            if ((fault_age > 40) || ($urandom % 600 == 0)) begin
                r_rst = 0;
                travel = $urandom_range(2, 26);
                if (pos > travel) pos = travel;
            end
            r_lu = (pos >= travel);
            r_ld = (pos == 0);
            if ($urandom % 300 == 0) begin r_lu = 1; r_ld = 1; end
            if (car_left > 0) begin
                r_car = 1; car_left--;
            end else begin
                r_car = 0;
                if ($urandom % 40 == 0) car_left = $urandom_range(1, 25);
            end
            r_op = ($urandom % 12 == 0);
            r_fr = ($urandom % 30 == 0);
            step(r_rst, r_op, r_fr, r_lu, r_ld, r_car);
            if (motor_up && pos < travel) pos++;
            else if (motor_down && pos > 0) pos--;
            fault_age = fault ? fault_age + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
